// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the IF stage: the NOP encoding used for IF/ID
// bubbles, the fetch FSM state encodings and the sequential PC increment.
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    // A fetch target is misaligned when its two low bits are not zero.
    function automatic logic is_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO used by the IF stage for the instruction buffer and
// for the queue of PCs belonging to outstanding fetches. A push into a full
// FIFO is accepted only when a pop happens in the same cycle. Clear has
// priority over push and pop.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   i_push/i_data  write request and data
//   i_pop          read request (head advances)
//   i_clear        empty the FIFO
//   o_data         head entry (valid when !o_empty)
//   o_full/o_empty/o_count  occupancy status
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_clear,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

    // Storage array; contents are only observed while the entry is occupied.
    always_ff @(posedge clk) begin
        if (w_push && !i_clear) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// IF stage: owns the PC, issues in-order word fetches over a req/gnt/rvalid
// handshake, buffers returned words with their PCs and drives the IF/ID
// pipeline registers. Handles EX redirects and hazard-unit stall/flush.
// Optional feature macro: IF_MISALIGN_TRAP_EN (adds PIP_misalign_o and the
// misaligned-redirect trap; without it redirect targets are word-aligned).
// Ports:
//   clk, reset_n                clock, synchronous active-low reset
//   imem_req_o/imem_addr_o      fetch request and word address
//   imem_gnt_i                  request accepted this cycle
//   imem_rvalid_i/imem_rdata_i  in-order response
//   redirect_i/redirect_pc_i    taken branch/jump from EX and its target
//   if_stall_i / if_flush_i     hold IF/ID / load a bubble into IF/ID
//   PIP_instr_o/PIP_pc_o        IF/ID instruction and PC
//   PIP_misalign_o              IF/ID misaligned-target trap flag (optional)
// -----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        if_stall_i,
    input  logic        if_flush_i,
    output logic [31:0] PIP_instr_o,
    output logic [31:0] PIP_pc_o
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        PIP_misalign_o
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(BUF_DEPTH);

    fetch_state_e r_state;
    logic [31:0]  r_fetch_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [31:0]  r_pip_instr;
    logic [31:0]  r_pip_pc;

    logic [31:0]  w_redirect_pc;
    logic         w_fetch_block;
    logic         w_credit_ok;
    logic         w_fire;
    logic         w_rsp_keep;
    logic         w_load;
    logic         w_bypass;
    logic         w_buf_push;
    logic         w_buf_pop;
    logic [CW-1:0] w_outst_next;

    logic [63:0]  w_buf_data;
    logic         w_buf_full;
    logic         w_buf_empty;
    logic [CW-1:0] w_buf_count;
    logic [31:0]  w_pcq_pc;
    logic         w_pcq_full;
    logic         w_pcq_empty;
    logic [CW-1:0] w_pcq_count;
    logic         w_unused;

`ifdef IF_MISALIGN_TRAP_EN
    logic r_trap_block;
    logic r_trap_pend;
    logic r_pip_misalign;
    logic w_redirect_mis;
    logic w_trap_load;

    assign w_redirect_pc  = redirect_pc_i;
    assign w_redirect_mis = is_misaligned(redirect_pc_i);
    assign w_fetch_block  = r_trap_block;
`else
    assign w_redirect_pc  = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_fetch_block  = 1'b0;
`endif

    // Outstanding fetches plus buffered words may never exceed the buffer
    // depth, so every response is guaranteed a buffer slot.
    assign w_credit_ok = ({1'b0, r_outst} + {1'b0, w_buf_count}) < {1'b0, DEPTH_CNT};
    assign imem_req_o  = (r_state == ST_FETCH) && !redirect_i && !w_fetch_block && w_credit_ok;
    assign imem_addr_o = r_fetch_pc;
    assign w_fire      = imem_req_o && imem_gnt_i;

    // Responses are kept only when they belong to the current fetch stream.
    assign w_rsp_keep  = imem_rvalid_i && (r_state == ST_FETCH) && !redirect_i;

    // IF/ID takes a new value this cycle; an empty buffer lets the incoming
    // response go straight to IF/ID, which sustains one instruction per cycle.
    assign w_load      = !redirect_i && !if_flush_i && !if_stall_i;
    assign w_buf_pop   = w_load && !w_buf_empty;
    assign w_bypass    = w_load && w_buf_empty && w_rsp_keep;
    assign w_buf_push  = w_rsp_keep && !w_bypass;

    // Every response retires one outstanding fetch, whether kept or dropped.
    assign w_outst_next = r_outst + CW'(w_fire) - CW'(imem_rvalid_i);

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (32)
    ) u_pc_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_fire),
        .i_data  (r_fetch_pc),
        .i_pop   (w_rsp_keep),
        .i_clear (redirect_i),
        .o_data  (w_pcq_pc),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty),
        .o_count (w_pcq_count)
    );

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_instr_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_buf_push),
        .i_data  ({w_pcq_pc, imem_rdata_i}),
        .i_pop   (w_buf_pop),
        .i_clear (redirect_i),
        .o_data  (w_buf_data),
        .o_full  (w_buf_full),
        .o_empty (w_buf_empty),
        .o_count (w_buf_count)
    );

    assign w_unused = &{1'b0, w_pcq_full, w_pcq_empty, w_pcq_count, w_buf_full};

    // Fetch PC, outstanding count and drain FSM.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= RESET_PC;
            r_outst    <= '0;
            r_discard  <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (redirect_i) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + PC_INCR;
            end else begin
                r_fetch_pc <= r_fetch_pc;
            end
            case (r_state)
                ST_FETCH: begin
                    // Wrong-path fetches still in flight must be swallowed.
                    if (redirect_i && (w_outst_next != '0)) begin
                        r_state   <= ST_DRAIN;
                        r_discard <= w_outst_next;
                    end else begin
                        r_state   <= ST_FETCH;
                        r_discard <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid_i) begin
                        r_discard <= r_discard - CW'(1);
                        if (r_discard == CW'(1)) begin
                            r_state <= ST_FETCH;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else begin
                        r_state   <= ST_DRAIN;
                        r_discard <= r_discard;
                    end
                end
                default: begin
                    r_state   <= ST_FETCH;
                    r_discard <= '0;
                end
            endcase
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // The trap is reported once IF/ID would otherwise take a bubble; the
    // target PC is still held in r_fetch_pc because fetching is blocked.
    assign w_trap_load = w_load && w_buf_empty && !w_rsp_keep && r_trap_pend;

    // Misaligned-target trap tracking and the IF/ID trap flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_trap_block   <= 1'b0;
            r_trap_pend    <= 1'b0;
            r_pip_misalign <= 1'b0;
        end else begin
            if (redirect_i) begin
                r_trap_block <= w_redirect_mis;
                r_trap_pend  <= w_redirect_mis;
            end else if (w_trap_load) begin
                r_trap_block <= r_trap_block;
                r_trap_pend  <= 1'b0;
            end else begin
                r_trap_block <= r_trap_block;
                r_trap_pend  <= r_trap_pend;
            end
            if (redirect_i || if_flush_i) begin
                r_pip_misalign <= 1'b0;
            end else if (if_stall_i) begin
                r_pip_misalign <= r_pip_misalign;
            end else begin
                r_pip_misalign <= w_trap_load;
            end
        end
    end

    assign PIP_misalign_o = r_pip_misalign;
`endif

    // IF/ID pipeline registers: redirect/flush > stall > buffer > bypass > bubble.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pip_instr <= NOP_INSTR;
            r_pip_pc    <= 32'h0000_0000;
        end else if (redirect_i || if_flush_i) begin
            r_pip_instr <= NOP_INSTR;
            r_pip_pc    <= 32'h0000_0000;
        end else if (if_stall_i) begin
            r_pip_instr <= r_pip_instr;
            r_pip_pc    <= r_pip_pc;
        end else if (!w_buf_empty) begin
            r_pip_instr <= w_buf_data[31:0];
            r_pip_pc    <= w_buf_data[63:32];
        end else if (w_rsp_keep) begin
            r_pip_instr <= imem_rdata_i;
            r_pip_pc    <= w_pcq_pc;
        end
`ifdef IF_MISALIGN_TRAP_EN
        else if (r_trap_pend) begin
            r_pip_instr <= NOP_INSTR;
            r_pip_pc    <= r_fetch_pc;
        end
`endif
        else begin
            r_pip_instr <= NOP_INSTR;
            r_pip_pc    <= 32'h0000_0000;
        end
    end

    assign PIP_instr_o = r_pip_instr;
    assign PIP_pc_o    = r_pip_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with a behavioural instruction memory
// that returns addr+0x100, in order, one cycle or more after the grant.
// Build with IF_MISALIGN_TRAP_EN defined to include the trap scenario.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        if_stall_i;
    logic        if_flush_i;
    logic [31:0] PIP_instr_o;
    logic [31:0] PIP_pc_o;
`ifdef IF_MISALIGN_TRAP_EN
    logic        PIP_misalign_o;
`endif

    int          n_cmp = 0;
    int          n_mis = 0;
    int          fires = 0;
    logic        mem_hold;
    logic [31:0] mem_q [$];

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_o     (imem_req_o),
        .imem_addr_o    (imem_addr_o),
        .imem_gnt_i     (imem_gnt_i),
        .imem_rvalid_i  (imem_rvalid_i),
        .imem_rdata_i   (imem_rdata_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .if_stall_i     (if_stall_i),
        .if_flush_i     (if_flush_i),
        .PIP_instr_o    (PIP_instr_o),
        .PIP_pc_o       (PIP_pc_o)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .PIP_misalign_o (PIP_misalign_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_pip(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
        check({tag, "_instr"}, PIP_instr_o, exp_instr);
        check({tag, "_pc"}, PIP_pc_o, exp_pc);
    endtask

    // One clock cycle: sample the handshake, take the edge, then let the
    // memory model present its next response (unless held back).
    task automatic step();
        logic        fire;
        logic [31:0] addr;
        #1;
        fire = imem_req_o && imem_gnt_i;
        addr = imem_addr_o;
        if (fire) fires++;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            mem_q.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'h0;
        end else begin
            if (fire) mem_q.push_back(addr);
            if (!mem_hold && (mem_q.size() > 0)) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_q.pop_front() + 32'h100;
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'h0;
            end
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        if_stall_i    = 1'b0;
        if_flush_i    = 1'b0;
        mem_hold      = 1'b0;

        // Reset state
        repeat (3) step();
        reset_n = 1'b1;
        check_pip("rst", NOP, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_req", {31'b0, imem_req_o}, 32'h1);

        // 1: streaming with always-grant 1-cycle memory
        imem_gnt_i = 1'b1;
        step();
        check_pip("t1_bubble", NOP, 32'h0);
        step();
        check_pip("t1_first", 32'h100, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check_pip("t1_seq", 32'h100 + 32'(4 * k), 32'(4 * k));
        end

        // 3: stall for 4 cycles mid-stream
        if_stall_i = 1'b1;
        fires = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_pip("t3_hold", 32'h110, 32'h10);
        end
        check("t3_reqs_le2", {31'b0, (fires <= 2)}, 32'h1);
        if_stall_i = 1'b0;
        for (int k = 5; k <= 8; k++) begin
            step();
            check_pip("t3_resume", 32'h100 + 32'(4 * k), 32'(4 * k));
        end

        // 4: redirect with two fetches outstanding
        mem_hold = 1'b1;
        step();
        check_pip("t4_pre", 32'h124, 32'h24);
        step();
        check_pip("t4_gap", NOP, 32'h0);
        check("t4_credit", {31'b0, imem_req_o}, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        mem_hold      = 1'b0;
        step();
        redirect_i = 1'b0;
        check_pip("t4_redir", NOP, 32'h0);
        check("t4_addr", imem_addr_o, 32'h200);
        step();
        check_pip("t4_drop1", NOP, 32'h0);
        check("t4_drain_req", {31'b0, imem_req_o}, 32'h0);
        step();
        check_pip("t4_drop2", NOP, 32'h0);
        step();
        check_pip("t4_refetch", NOP, 32'h0);
        step();
        check_pip("t4_target", 32'h300, 32'h200);

        // 5: redirect coincident with rvalid and stall
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h400;
        if_stall_i    = 1'b1;
        step();
        redirect_i = 1'b0;
        if_stall_i = 1'b0;
        check_pip("t5_redir", NOP, 32'h0);
        check("t5_addr", imem_addr_o, 32'h400);
        step();
        check_pip("t5_bubble", NOP, 32'h0);
        step();
        check_pip("t5_target", 32'h500, 32'h400);
        step();
        check_pip("t5_next", 32'h504, 32'h404);

        // 2: grant withheld for 5 cycles after reset
        reset_n    = 1'b0;
        imem_gnt_i = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check_pip("t2_nogrant", NOP, 32'h0);
            check("t2_addr", imem_addr_o, 32'h0);
        end
        imem_gnt_i = 1'b1;
        step();
        check_pip("t2_bubble", NOP, 32'h0);
        step();
        check_pip("t2_first", 32'h100, 32'h0);
        step();
        check_pip("t2_second", 32'h104, 32'h4);

`ifdef IF_MISALIGN_TRAP_EN
        // 6: misaligned redirect target traps and blocks fetching
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h202;
        step();
        redirect_i = 1'b0;
        check_pip("t6_redir", NOP, 32'h0);
        check("t6_mis0", {31'b0, PIP_misalign_o}, 32'h0);
        check("t6_noreq0", {31'b0, imem_req_o}, 32'h0);
        step();
        check_pip("t6_trap", NOP, 32'h202);
        check("t6_mis1", {31'b0, PIP_misalign_o}, 32'h1);
        check("t6_noreq1", {31'b0, imem_req_o}, 32'h0);
        step();
        check_pip("t6_after", NOP, 32'h0);
        check("t6_mis2", {31'b0, PIP_misalign_o}, 32'h0);
        check("t6_noreq2", {31'b0, imem_req_o}, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h300;
        step();
        redirect_i = 1'b0;
        check("t6_addr", imem_addr_o, 32'h300);
        check("t6_req", {31'b0, imem_req_o}, 32'h1);
        step();
        check_pip("t6_bubble", NOP, 32'h0);
        step();
        check_pip("t6_resume", 32'h400, 32'h300);
        check("t6_mis3", {31'b0, PIP_misalign_o}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
